// File: rtl/sram_access_arbiter_pkg.sv
// Shared constants for the SRAM access arbiter: FSM encodings, grant identifiers
// and the default lowest CPU-writable address.
package sram_access_arbiter_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_RESP   = 2'd2;

    localparam logic GRANT_A = 1'b0;
    localparam logic GRANT_B = 1'b1;

    localparam int WP_BASE_DEFAULT = 13;

endpackage

// File: rtl/sram_access_arbiter_rr_select.sv
// Combinational two-way round-robin pick: on a tie the port that did not win last time
// is granted; a lone requester always wins.
import sram_access_arbiter_pkg::*;

module arb_rr_select (
    input  logic a_req_i,
    input  logic b_req_i,
    input  logic last_grant_i,
    output logic grant_a_o,
    output logic grant_b_o
);

    assign grant_a_o = a_req_i & (~b_req_i | (last_grant_i == GRANT_B));
    assign grant_b_o = b_req_i & (~a_req_i | (last_grant_i == GRANT_A));

endmodule

// File: rtl/sram_access_arbiter.sv
// Shares one single-port SRAM between ports A and B, one access per 3 cycles.
// Build option SRAM_WP_EN: blocks port-A writes below WP_BASE and reports them via a_err.
import sram_access_arbiter_pkg::*;

module sram_access_arbiter #(
    parameter int AW      = 4,
    parameter int DW      = 8,
    parameter int WP_BASE = WP_BASE_DEFAULT
) (
    input  logic          clk,
    input  logic          sys_rst,
    input  logic          a_req,
    input  logic          a_we,
    input  logic [AW-1:0] a_addr,
    input  logic [DW-1:0] a_wdata,
    output logic          a_ack,
    output logic [DW-1:0] a_rdata,
    output logic          a_err,
    input  logic          b_req,
    input  logic          b_we,
    input  logic [AW-1:0] b_addr,
    input  logic [DW-1:0] b_wdata,
    output logic          b_ack,
    output logic [DW-1:0] b_rdata,
    output logic          b_err,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_we,
    input  logic [DW-1:0] mem_rdata
);

`ifdef SRAM_WP_EN
    localparam logic WP_ENABLE = 1'b1;
`else
    localparam logic WP_ENABLE = 1'b0;
`endif
    localparam logic [AW-1:0] WP_BASE_A = AW'(WP_BASE);

    logic [1:0]    state_q, state_d;
    logic          last_grant_q, last_grant_d;
    logic          we_q, we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic [DW-1:0] a_rdata_q, a_rdata_d;
    logic [DW-1:0] b_rdata_q, b_rdata_d;
    logic          pick_a, pick_b;
    logic          granted_a;
    logic          fault;

    arb_rr_select u_rr_select (
        .a_req_i      (a_req),
        .b_req_i      (b_req),
        .last_grant_i (last_grant_q),
        .grant_a_o    (pick_a),
        .grant_b_o    (pick_b)
    );

    // last_grant doubles as "port owning the current access" once we leave IDLE.
    assign granted_a = (last_grant_q == GRANT_A);
    assign fault     = WP_ENABLE & granted_a & we_q & (mem_addr_q < WP_BASE_A);

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        we_d         = we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        a_rdata_d    = a_rdata_q;
        b_rdata_d    = b_rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_a) begin
                    last_grant_d = GRANT_A;
                    we_d         = a_we;
                    mem_addr_d   = a_addr;
                    mem_wdata_d  = a_wdata;
                    state_d      = ST_ACCESS;
                end else if (pick_b) begin
                    last_grant_d = GRANT_B;
                    we_d         = b_we;
                    mem_addr_d   = b_addr;
                    mem_wdata_d  = b_wdata;
                    state_d      = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                // Sampled before the write lands, so a write returns the old contents.
                if (granted_a) begin
                    a_rdata_d = mem_rdata;
                end else begin
                    b_rdata_d = mem_rdata;
                end
                state_d = ST_RESP;
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (sys_rst) begin
            state_q      <= ST_IDLE;
            last_grant_q <= GRANT_B;
            we_q         <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            a_rdata_q    <= '0;
            b_rdata_q    <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            we_q         <= we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            a_rdata_q    <= a_rdata_d;
            b_rdata_q    <= b_rdata_d;
        end
    end

    assign mem_we    = (state_q == ST_ACCESS) & we_q & ~fault;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

    assign a_ack   = (state_q == ST_RESP) & granted_a;
    assign b_ack   = (state_q == ST_RESP) & ~granted_a;
    assign a_err   = a_ack & fault;
    assign b_err   = b_ack & fault;
    assign a_rdata = a_rdata_q;
    assign b_rdata = b_rdata_q;

endmodule

// File: tb/tb_sram_access_arbiter.sv
// Directed bench for sram_access_arbiter with a behavioural 16-byte SRAM.
`timescale 1ns/1ps
module tb_sram_access_arbiter;

`ifdef SRAM_WP_EN
    localparam bit WP_ON = 1'b1;
`else
    localparam bit WP_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       sys_rst = 1'b1;
    logic       a_req = 0, a_we = 0, b_req = 0, b_we = 0;
    logic [3:0] a_addr = 0, b_addr = 0;
    logic [7:0] a_wdata = 0, b_wdata = 0;
    logic       a_ack, a_err, b_ack, b_err, mem_we;
    logic [7:0] a_rdata, b_rdata, mem_wdata, mem_rdata;
    logic [3:0] mem_addr;

    logic [7:0] sram [16];
    int         we_cnt = 0;
    logic [3:0] we_addr = 0;
    int         n_tests = 0;
    int         n_fail = 0;

    always #5 clk = ~clk;

    sram_access_arbiter dut (
        .clk(clk), .sys_rst(sys_rst),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_ack(a_ack), .a_rdata(a_rdata), .a_err(a_err),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_ack(b_ack), .b_rdata(b_rdata), .b_err(b_err),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_rdata(mem_rdata)
    );

    assign mem_rdata = sram[mem_addr];
    always @(posedge clk) begin
        if (mem_we) begin
            sram[mem_addr] <= mem_wdata;
            we_cnt  = we_cnt + 1;
            we_addr = mem_addr;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end else begin
            $display("[TB] ok   %s: 0x%0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One transaction from an idle FSM; lat counts edges from req to ack.
    task automatic txn(input bit port_b, input bit we, input logic [3:0] addr,
                       input logic [7:0] wd, output logic [7:0] rd, output bit err,
                       output int lat);
        if (port_b) begin
            b_req = 1; b_we = we; b_addr = addr; b_wdata = wd;
        end else begin
            a_req = 1; a_we = we; a_addr = addr; a_wdata = wd;
        end
        lat = 0;
        rd  = 8'h00;
        err = 1'b0;
        forever begin
            tick();
            lat++;
            if (port_b ? b_ack : a_ack) begin
                rd  = port_b ? b_rdata : a_rdata;
                err = port_b ? b_err : a_err;
                break;
            end
            if (lat > 10) begin
                check("ack_timeout", 32'(lat), 32'd2);
                break;
            end
        end
        a_req = 0;
        b_req = 0;
        tick();
    endtask

    logic [7:0] rd;
    bit         err;
    int         lat;
    int         acks;
    string      order;

    initial begin
        for (int i = 0; i < 16; i++) sram[i] = 8'(i * 16 + 1);
        sram[3] = 8'h5A;
        sram[2] = 8'h22;
        sram[5] = 8'hA5;
        sram[9] = 8'h99;
        sram[14] = 8'h11;

        // Reset state
        repeat (3) tick();
        check("rst_a_ack", a_ack, 0);
        check("rst_b_ack", b_ack, 0);
        check("rst_rdata", {a_rdata, b_rdata}, 0);
        check("rst_errs", {a_err, b_err}, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr_wdata", {mem_addr, mem_wdata}, 0);
        sys_rst = 0;
        tick();

        // 1: A reads addr 3
        we_cnt = 0;
        txn(0, 0, 4'd3, 8'h00, rd, err, lat);
        check("t1_rdata", rd, 8'h5A);
        check("t1_err", err, 0);
        check("t1_latency", lat, 2);
        check("t1_no_write", we_cnt, 0);

        // 2: A writes 0x77 to 14 (ack returns old contents), then reads back
        we_cnt = 0;
        txn(0, 1, 4'd14, 8'h77, rd, err, lat);
        check("t2_write_old_rdata", rd, 8'h11);
        check("t2_we_count", we_cnt, 1);
        check("t2_we_addr", we_addr, 4'd14);
        txn(0, 0, 4'd14, 8'h00, rd, err, lat);
        check("t2_readback", rd, 8'h77);

        // 3: A write below the protected boundary, then the same write from B
        we_cnt = 0;
        txn(0, 1, 4'd2, 8'hFF, rd, err, lat);
        check("t3_a_err", err, WP_ON ? 1 : 0);
        check("t3_a_we_count", we_cnt, WP_ON ? 0 : 1);
        check("t3_mem2_after_a", sram[2], WP_ON ? 8'h22 : 8'hFF);
        check("t3_a_latency", lat, 2);
        txn(1, 1, 4'd2, 8'hFF, rd, err, lat);
        check("t3_b_err", err, 0);
        check("t3_mem2_after_b", sram[2], 8'hFF);
        check("t3_a_rdata_held", a_rdata, WP_ON ? 8'h22 : 8'h22);

        // 4: sustained contention after reset alternates A,B,A,B
        sys_rst = 1; tick(); sys_rst = 0;
        a_req = 1; a_we = 0; a_addr = 4'd3;
        b_req = 1; b_we = 0; b_addr = 4'd9;
        acks = 0;
        order = "";
        for (int c = 0; c < 12; c++) begin
            tick();
            if (a_ack && b_ack) check("t4_dual_ack", 1, 0);
            if (a_ack) begin acks++; order = {order, "A"}; end
            if (b_ack) begin acks++; order = {order, "B"}; end
        end
        a_req = 0; b_req = 0;
        repeat (3) tick();
        check("t4_ack_count", acks, 4);
        check("t4_order_ABAB", order == "ABAB", 1);
        check("t4_rdata", {a_rdata, b_rdata}, 16'h5A99);

        // 5: reset during ACCESS of a B write
        b_req = 1; b_we = 1; b_addr = 4'd10; b_wdata = 8'h33;
        tick();
        check("t5_access_we", mem_we, 1);
        sys_rst = 1;
        tick();
        b_req = 0; sys_rst = 0;
        check("t5_we_dropped", mem_we, 0);
        check("t5_no_ack_now", b_ack, 0);
        acks = 0;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (b_ack) acks++;
        end
        check("t5_no_late_ack", acks, 0);
        txn(0, 0, 4'd3, 8'h00, rd, err, lat);
        check("t5_idle_latency", lat, 2);

        // 6: A moves its address after grant; the latched address wins
        a_req = 1; a_we = 0; a_addr = 4'd5;
        tick();
        a_addr = 4'd9;
        lat = 1;
        while (!a_ack && lat < 10) begin
            tick();
            lat++;
        end
        check("t6_latency", lat, 2);
        check("t6_rdata", a_rdata, 8'hA5);
        a_req = 0;
        repeat (3) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
